ct_l2c_data_ram_ctrl: RTL and testbench

- Access sequencer directly upstream of the L2 data-array macro ct_spsram_32768x128.
- Accepts one read or write request at a time over a valid/ready handshake.
- Drives the macro's active-low CEN/GWEN/WEN pins, holds A/D stable for a multi-cycle access window, and captures Q into a one-entry response buffer with backpressure.

---
 rtl/ct_l2c_data_ram_ctrl_pkg.sv | 27 ++
 rtl/ct_l2c_data_ram_ctrl_rsp_buf.sv | 36 +++
 rtl/ct_l2c_data_ram_ctrl.sv | 138 +++++++++++++
 tb/tb_ct_l2c_data_ram_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_l2c_data_ram_ctrl_pkg.sv
// ct_l2c_ram_pkg: shared types and defaults for the L2 data-RAM access
// sequencer (ct_l2c_data_ram_ctrl) and its response buffer.
//   state_e  - sequencer FSM encoding (IDLE / ACCESS)
//   cnt_t    - access-window cycle counter
//   *_DEF    - default geometry and access latency of ct_spsram_32768x128
package ct_l2c_ram_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int unsigned ADDR_WIDTH_DEF = 15;
  localparam int unsigned DATA_WIDTH_DEF = 128;
  localparam int unsigned ACC_LAT_DEF    = 2;

  // Wide enough for every legal window length (1..4 cycles).
  localparam int unsigned CNT_W = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter value in the final cycle of an access window.
  function automatic cnt_t last_cnt(input int unsigned acc_lat);
    return cnt_t'(acc_lat - 1);
  endfunction

endpackage

// File: rtl/ct_l2c_data_ram_ctrl_rsp_buf.sv
// ct_l2c_rsp_buf: one-entry valid/ready register holding SRAM read data
// until the consumer takes it.
//   CLK, RST   - clock, asynchronous active-high reset
//   load       - one-cycle strobe: capture load_data and raise rsp_vld
//   load_data  - data captured on load
//   rsp_vld    - entry valid
//   rsp_rdy    - consumer accepts the entry this cycle
//   rsp_data   - entry contents, stable while rsp_vld is held
module ct_l2c_rsp_buf
  import ct_l2c_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  // A load in the same edge as a handshake wins: the new entry stays valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
    end else if (load) begin
      rsp_vld  <= 1'b1;
      rsp_data <= load_data;
    end else if (rsp_vld && rsp_rdy) begin
      rsp_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/ct_l2c_data_ram_ctrl.sv
// ct_l2c_data_ram_ctrl: access sequencer in front of ct_spsram_32768x128.
// Takes one read/write request at a time, drives the macro's active-low
// CEN/GWEN/WEN pins from registers, holds A/D for an ACC_LAT-cycle window
// and captures Q into a one-entry response buffer.
//   CLK, RST                     - clock, asynchronous active-high reset
//   req_vld/req_rdy              - request handshake
//   req_wr/addr/wdata/wmask      - request payload (wmask active-high)
//   rsp_vld/rsp_rdy/rsp_data     - read response handshake
//   busy                         - FSM not IDLE
//   sram_a/cen/gwen/wen/d, sram_q - macro interface
// Optional: define CT_L2C_RAM_PERF_CNT_EN to add perf_clr, perf_rd_cnt and
// perf_wr_cnt (accepted read/write counters).
module ct_l2c_data_ram_ctrl
  import ct_l2c_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_LAT    = ACC_LAT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
`ifdef CT_L2C_RAM_PERF_CNT_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt
`endif
);

  state_e state;
  cnt_t   cnt;
  logic   accept;
  logic   win_end;
  logic   rsp_load;

  assign busy = (state == ACCESS);

  // Reads need a free (or draining) response slot; writes never respond.
  always_comb begin
    req_rdy = 1'b0;
    if (state == IDLE) begin
      req_rdy = req_wr ? 1'b1 : (!rsp_vld || rsp_rdy);
    end
  end

  assign accept  = req_vld && req_rdy;
  assign win_end = (state == ACCESS) && (cnt == last_cnt(ACC_LAT));
  // GWEN stays high for the whole window of a read, so it doubles as the
  // read/write flag of the access in flight.
  assign rsp_load = win_end && sram_gwen;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= ACCESS;
            cnt       <= '0;
            sram_cen  <= 1'b0;
            sram_a    <= req_addr;
            sram_gwen <= !req_wr;
            if (req_wr) begin
              sram_wen <= ~req_wmask;
              sram_d   <= req_wdata;
            end else begin
              sram_wen <= '1;
            end
          end
        end
        ACCESS: begin
          // CEN is a single-cycle strobe at the start of the window.
          sram_cen <= 1'b1;
          if (win_end) begin
            state     <= IDLE;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
      endcase
    end
  end

  ct_l2c_rsp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_buf (
    .CLK      (CLK),
    .RST      (RST),
    .load     (rsp_load),
    .load_data(sram_q),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_data (rsp_data)
  );

`ifdef CT_L2C_RAM_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else if (perf_clr) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else if (accept) begin
      if (req_wr) perf_wr_cnt <= perf_wr_cnt + 32'd1;
      else        perf_rd_cnt <= perf_rd_cnt + 32'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_ct_l2c_data_ram_ctrl.sv
// Bench for ct_l2c_data_ram_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model (reference memory, window timing by cycle number,
// one-slot response buffer). A small behavioural SRAM macro answers the DUT.
module tb_ct_l2c_data_ram_ctrl;

  localparam int AW = 15;
  localparam int DW = 128;
  localparam int ACC_LAT = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_wmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d;
  logic [DW-1:0] sram_q = '0;
`ifdef CT_L2C_RAM_PERF_CNT_EN
  logic          perf_clr;
  logic [31:0]   perf_rd_cnt, perf_wr_cnt;
  logic [31:0]   m_prd, m_pwr;
`endif

  ct_l2c_data_ram_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ACC_LAT   (ACC_LAT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .busy(busy),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
`ifdef CT_L2C_RAM_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Behavioural macro: word array indexed by the low address nibble (all
  // stimulus uses addresses 0x1230..0x123F), Q registered on a CEN-low edge.
  logic [DW-1:0] sram_mem [16];
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        sram_mem[sram_a[3:0]] <= (sram_mem[sram_a[3:0]] & sram_wen) | (sram_d & ~sram_wen);
      sram_q <= sram_mem[sram_a[3:0]];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [16];
  int            cyc = 0;
  bit            m_act;
  int            m_acc;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_mask, m_dhold, m_exp_rd, m_rdata;
  bit            m_rvld;
  bit            in_win, exp_rdy, hs_m, acc_m;

  // Compare process: one check set per cycle, inputs are stable at negedge.
  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_cen", sram_cen, 1'b1);
      chk("rst_gwen", sram_gwen, 1'b1);
      chk("rst_wen", sram_wen, '1);
      chk("rst_a", sram_a, '0);
      chk("rst_d", sram_d, '0);
      chk("rst_rsp_vld", rsp_vld, 1'b0);
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_busy", busy, 1'b0);
      m_act = 0; m_rvld = 0; m_dhold = '0; m_rdata = '0;
`ifdef CT_L2C_RAM_PERF_CNT_EN
      m_prd = 0; m_pwr = 0;
      chk("rst_perf_rd", perf_rd_cnt, '0);
      chk("rst_perf_wr", perf_wr_cnt, '0);
`endif
    end else begin
      in_win = m_act && (cyc >= m_acc + 1) && (cyc <= m_acc + ACC_LAT);
      exp_rdy = in_win ? 1'b0 : (req_wr ? 1'b1 : (!m_rvld || rsp_rdy));
      chk("busy", busy, in_win);
      chk("cen", sram_cen, !(m_act && cyc == m_acc + 1));
      chk("gwen", sram_gwen, in_win ? !m_wr : 1'b1);
      chk("wen", sram_wen, (in_win && m_wr) ? ~m_mask : '1);
      if (in_win) begin
        chk("a", sram_a, m_addr);
        chk("d", sram_d, m_wr ? m_wdata : m_dhold);
      end
      chk("req_rdy", req_rdy, exp_rdy);
      chk("rsp_vld", rsp_vld, m_rvld);
      if (m_rvld) chk("rsp_data", rsp_data, m_rdata);
`ifdef CT_L2C_RAM_PERF_CNT_EN
      chk("perf_rd", perf_rd_cnt, m_prd);
      chk("perf_wr", perf_wr_cnt, m_pwr);
`endif
      // Advance the model across the coming clock edge.
      hs_m  = m_rvld && rsp_rdy;
      acc_m = req_vld && exp_rdy;
      if (m_act && cyc == m_acc + ACC_LAT) begin
        m_act = 0;
        if (!m_wr) begin
          m_rvld = 1; m_rdata = m_exp_rd;
        end else if (hs_m) m_rvld = 0;
      end else if (hs_m) m_rvld = 0;
`ifdef CT_L2C_RAM_PERF_CNT_EN
      if (perf_clr) begin
        m_prd = 0; m_pwr = 0;
      end else if (acc_m) begin
        if (req_wr) m_pwr = m_pwr + 1;
        else        m_prd = m_prd + 1;
      end
`endif
      if (acc_m) begin
        m_act = 1; m_acc = cyc; m_wr = req_wr; m_addr = req_addr;
        m_wdata = req_wdata; m_mask = req_wmask;
        if (req_wr) begin
          m_dhold = req_wdata;
          ref_mem[req_addr[3:0]] = (ref_mem[req_addr[3:0]] & ~req_wmask) | (req_wdata & req_wmask);
        end else begin
          m_exp_rd = ref_mem[req_addr[3:0]];
        end
      end
    end
    cyc++;
  end

  // Present a request at posedge+1, wait (bounded) for the handshake and
  // return at posedge+1 of the first window cycle.
  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                      input logic [DW-1:0] mk);
    int k;
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = dt; req_wmask = mk;
    k = 0;
    @(negedge CLK);
    while (!req_rdy && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (!req_rdy) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got req_rdy=0 expected 1 within 20 cycles");
    end
    @(posedge CLK); #1;
    req_vld = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  logic [DW-1:0] pat_a5, pat_x, pat_p, m_sel;
  bit            hs;

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    pat_a5 = {16{8'hA5}};
    pat_x  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    pat_p  = 128'h1111_2222_3333_4444_5555_6666_7777_BEEF;
    RST = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b0;
`ifdef CT_L2C_RAM_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Full write, ACC_LAT=2.
    send(1'b1, 15'h1234, pat_a5, '1);
    chk("w_cen_t1", sram_cen, 1'b0);
    chk("w_wen_t1", sram_wen, '0);
    chk("w_gwen_t1", sram_gwen, 1'b0);
    chk("w_a_t1", sram_a, 15'h1234);
    chk("w_d_t1", sram_d, pat_a5);
    tick();
    chk("w_cen_t2", sram_cen, 1'b1);
    chk("w_a_t2", sram_a, 15'h1234);
    chk("w_d_t2", sram_d, pat_a5);
    chk("w_gwen_t2", sram_gwen, 1'b0);
    tick();
    chk("w_rdy_t3", req_rdy, 1'b1);
    chk("w_busy_t3", busy, 1'b0);

    // Read back, response held by rsp_rdy=0.
    send(1'b0, 15'h1234, '0, '0);
    chk("r_cen_t1", sram_cen, 1'b0);
    chk("r_gwen_t1", sram_gwen, 1'b1);
    chk("r_wen_t1", sram_wen, '1);
    tick();
    chk("r_gwen_t2", sram_gwen, 1'b1);
    chk("r_vld_t2", rsp_vld, 1'b0);
    tick();
    chk("r_vld_t3", rsp_vld, 1'b1);
    chk("r_data_t3", rsp_data, pat_a5);

    // Backpressure: read blocked, write still accepted.
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 15'h1235;
    #1 chk("bp_rd_rdy", req_rdy, 1'b0);
    tick();
    chk("bp_rd_not_acc", busy, 1'b0);
    req_vld = 1'b0;
    send(1'b1, 15'h1235, pat_x, '1);
    chk("bp_wr_busy", busy, 1'b1);
    tick(); tick();
    chk("bp_hold_vld", rsp_vld, 1'b1);
    chk("bp_hold_data", rsp_data, pat_a5);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 15'h1235;
    #1 chk("bp_rd_rdy2", req_rdy, 1'b0);
    tick();
    rsp_rdy = 1'b1;
    #1 chk("bp_rd_rdy_drain", req_rdy, 1'b1);
    tick();
    req_vld = 1'b0; rsp_rdy = 1'b0;
    chk("bp_drained", rsp_vld, 1'b0);
    chk("bp_acc_busy", busy, 1'b1);
    tick(); tick();
    chk("bp_new_vld", rsp_vld, 1'b1);
    chk("bp_new_data", rsp_data, pat_x);

    // Partial write of the low 16 bits, then read-merge check.
    rsp_rdy = 1'b1;
    send(1'b1, 15'h1234, pat_p, 128'hFFFF);
    chk("pw_wen", sram_wen, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000);
    tick(); tick();
    send(1'b0, 15'h1234, '0, '0);
    tick(); tick();
    chk("pw_rd_vld", rsp_vld, 1'b1);
    chk("pw_rd_data", rsp_data, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_BEEF);

    // Reset in the first window cycle of a read.
    tick();
    send(1'b0, 15'h1236, '0, '0);
    RST = 1'b1;
    #1;
    chk("rm_cen", sram_cen, 1'b1);
    chk("rm_busy", busy, 1'b0);
    chk("rm_vld", rsp_vld, 1'b0);
    tick();
    RST = 1'b0;
    tick(); tick(); tick();
    chk("rm_no_rsp", rsp_vld, 1'b0);
    chk("rm_idle", busy, 1'b0);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 800; n++) begin
      @(negedge CLK);
      hs = req_vld && req_rdy;
      @(posedge CLK); #1;
      if (!req_vld || hs) begin
        req_vld   = ($urandom % 4) != 0;
        req_wr    = $urandom % 2;
        req_addr  = {11'h123, 4'($urandom)};
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom % 3)
          0:       m_sel = '1;
          1:       m_sel = 128'hFFFF;
          default: m_sel = {$urandom, $urandom, $urandom, $urandom};
        endcase
        req_wmask = m_sel;
      end
      rsp_rdy = ($urandom % 3) != 0;
`ifdef CT_L2C_RAM_PERF_CNT_EN
      perf_clr = ($urandom % 32) == 0;
`endif
    end
    @(negedge CLK);
    hs = req_vld && req_rdy;
    @(posedge CLK); #1;
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    repeat (ACC_LAT + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
